// File: rtl/eros_obi_master_arbiter.sv
// ---------------------------------------------------------------------------
// eros_obi_master_arbiter
//
// Shares the single EROS external-master OBI port between NREQ OBI managers
// (for example the APB->OBI bridge path and a debug/DMA manager).
// Arbitration is round-robin. Once a request is presented downstream and not
// granted, it is locked so the downstream address phase stays stable. An
// in-order ID FIFO remembers which manager issued each outstanding
// transaction, so every response is routed back to its issuer.
//
// Parameters:
//   NREQ      number of managers (2..8)
//   AW, DW    address / data width (byte enables are DW/8 wide)
//   MAX_OUTST maximum in-flight transactions (power of 2, >= 2)
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   m_req_i/we/be/addr/wdata per-manager address phase, manager k at slice k
//   m_gnt_o, m_rvalid_o     per-manager grant / response valid
//   m_rdata_o               read data, broadcast to all managers
//   s_*                     downstream OBI port
//   busy_o                  transaction in flight or request locked
//   err_o                   sticky: response seen with nothing outstanding
//   perf_gnt_cnt_o          per-manager saturating grant counters
//
// Optional feature macro: EROS_OBI_ARB_PERF_EN
//   defined   : 32-bit per-manager handshake counters drive perf_gnt_cnt_o
//   undefined : no counters, perf_gnt_cnt_o is tied to 0
//
// Every output is forced to 0 while rst_i is high, including the purely
// combinational paths.
// ---------------------------------------------------------------------------
module eros_obi_master_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        m_req_i,
  input  logic [NREQ-1:0]        m_we_i,
  input  logic [NREQ*DW/8-1:0]   m_be_i,
  input  logic [NREQ*AW-1:0]     m_addr_i,
  input  logic [NREQ*DW-1:0]     m_wdata_i,
  output logic [NREQ-1:0]        m_gnt_o,
  output logic [NREQ-1:0]        m_rvalid_o,
  output logic [DW-1:0]          m_rdata_o,
  output logic                   s_req_o,
  output logic                   s_we_o,
  output logic [DW/8-1:0]        s_be_o,
  output logic [AW-1:0]          s_addr_o,
  output logic [DW-1:0]          s_wdata_o,
  input  logic                   s_gnt_i,
  input  logic                   s_rvalid_i,
  input  logic [DW-1:0]          s_rdata_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [NREQ*32-1:0]     perf_gnt_cnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam int BW = DW / 8;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_idx;
  logic          lock;
  logic [IW-1:0] search_idx;
  logic [IW-1:0] winner;
  logic          found;
  int            cand;

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] fifo_mem [MAX_OUTST];
  logic [IW-1:0] fifo_head;
  logic          err;

  logic          issue;
  logic          hs;
  logic          pop;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    cand       = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(rr_ptr) + i) % NREQ;
      if (!found && m_req_i[cand]) begin
        found      = 1'b1;
        search_idx = cand[IW-1:0];
      end
    end
  end

  // A locked manager keeps the port even if others request meanwhile.
  assign winner    = lock ? lock_idx : search_idx;
  assign fifo_head = fifo_mem[rd_ptr];

  // No bypass when full: a same-cycle pop does not free a slot for issue.
  assign issue = ~rst_i & ((|m_req_i) | lock) & (count < CW'(MAX_OUTST));
  assign hs    = issue & s_gnt_i;
  assign pop   = ~rst_i & s_rvalid_i & (count != '0);

  assign s_req_o   = issue;
  assign s_we_o    = issue & m_we_i[winner];
  assign s_be_o    = issue ? m_be_i[int'(winner)*BW +: BW]    : '0;
  assign s_addr_o  = issue ? m_addr_i[int'(winner)*AW +: AW]  : '0;
  assign s_wdata_o = issue ? m_wdata_i[int'(winner)*DW +: DW] : '0;

  assign m_rdata_o = rst_i ? '0 : s_rdata_i;
  assign busy_o    = ~rst_i & ((count != '0) | lock);
  assign err_o     = ~rst_i & err;

  // Grant and response valid are one-hot decodes of winner and FIFO head.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      m_gnt_o[k]    = hs  & (winner    == IW'(k));
      m_rvalid_o[k] = pop & (fifo_head == IW'(k));
    end
  end

  // Arbitration state, FIFO pointers/count and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      if (hs) begin
        lock   <= 1'b0;
        rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (issue) begin
        lock     <= 1'b1;
        lock_idx <= winner;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_rvalid_i && (count == '0)) begin
        err <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: entries are only read when count > 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i && hs) begin
      fifo_mem[wr_ptr] <= winner;
    end
  end

`ifdef EROS_OBI_ARB_PERF_EN
  logic [31:0] perf_cnt [NREQ];

  // Saturating per-manager handshake counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NREQ; k++) begin
        perf_cnt[k] <= '0;
      end
    end else if (hs && (perf_cnt[winner] != 32'hFFFF_FFFF)) begin
      perf_cnt[winner] <= perf_cnt[winner] + 32'd1;
    end
  end

  // Pack the counters, manager k at slice k.
  always_comb begin
    perf_gnt_cnt_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      perf_gnt_cnt_o[k*32 +: 32] = rst_i ? 32'd0 : perf_cnt[k];
    end
  end
`else
  assign perf_gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_eros_obi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eros_obi_master_arbiter
//
// Randomised bench for eros_obi_master_arbiter with NREQ=2, MAX_OUTST=4.
// Bench-side managers hold an address phase until granted. The bench-side
// slave returns read data in order. The reference model tracks the last
// winner, which manager is left waiting on the port, and how many
// transactions are in flight. Expected responses are queued at each
// handshake, and a separate monitor pops and checks them whenever the DUT
// raises m_rvalid_o.
// ---------------------------------------------------------------------------
module tb_eros_obi_master_arbiter;

  localparam int NREQ      = 2;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_OUTST = 4;
  localparam int BW        = DW / 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [NREQ-1:0]      m_req_i = '0;
  logic [NREQ-1:0]      m_we_i = '0;
  logic [NREQ*BW-1:0]   m_be_i = '0;
  logic [NREQ*AW-1:0]   m_addr_i = '0;
  logic [NREQ*DW-1:0]   m_wdata_i = '0;
  logic [NREQ-1:0]      m_gnt_o;
  logic [NREQ-1:0]      m_rvalid_o;
  logic [DW-1:0]        m_rdata_o;
  logic                 s_req_o;
  logic                 s_we_o;
  logic [BW-1:0]        s_be_o;
  logic [AW-1:0]        s_addr_o;
  logic [DW-1:0]        s_wdata_o;
  logic                 s_gnt_i = 1'b0;
  logic                 s_rvalid_i = 1'b0;
  logic [DW-1:0]        s_rdata_i = '0;
  logic                 busy_o;
  logic                 err_o;
  logic [NREQ*32-1:0]   perf_gnt_cnt_o;

  eros_obi_master_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .busy_o(busy_o), .err_o(err_o), .perf_gnt_cnt_o(perf_gnt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
  } rsp_t;

  int total = 0;
  int bad   = 0;

  // Bench-side manager address phases.
  logic        drv_req   [NREQ];
  logic        drv_we    [NREQ];
  logic [3:0]  drv_be    [NREQ];
  logic [31:0] drv_addr  [NREQ];
  logic [31:0] drv_wdata [NREQ];

  // Reference model state.
  int          last_win;
  int          held;
  int          outst;
  bit          err_exp;
  int          perf_exp [NREQ];
  rsp_t        exp_q [$];
  logic [31:0] slave_q [$];

  // Stimulus knobs (percentages) and a forced-response override.
  int p_new = 0;
  int p_gnt = 0;
  int p_rv  = 0;
  bit force_rv = 1'b0;

  task automatic check_value(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    last_win = NREQ - 1;
    held     = -1;
    outst    = 0;
    err_exp  = 1'b0;
    for (int k = 0; k < NREQ; k++) perf_exp[k] = 0;
    exp_q.delete();
    slave_q.delete();
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < NREQ; k++) begin
      if (!drv_req[k] && ($urandom_range(0, 99) < p_new)) begin
        drv_req[k]   = 1'b1;
        drv_we[k]    = 1'($urandom_range(0, 1));
        drv_be[k]    = 4'($urandom);
        drv_addr[k]  = $urandom;
        drv_wdata[k] = $urandom;
      end
      m_req_i[k]            = drv_req[k];
      m_we_i[k]             = drv_we[k];
      m_be_i[k*BW +: BW]    = drv_be[k];
      m_addr_i[k*AW +: AW]  = drv_addr[k];
      m_wdata_i[k*DW +: DW] = drv_wdata[k];
    end
    s_gnt_i = ($urandom_range(0, 99) < p_gnt);
    if (force_rv) begin
      s_rvalid_i = 1'b1;
      s_rdata_i  = $urandom;
    end else if ((slave_q.size() > 0) && ($urandom_range(0, 99) < p_rv)) begin
      s_rvalid_i = 1'b1;
      s_rdata_i  = slave_q.pop_front();
    end else begin
      s_rvalid_i = 1'b0;
      s_rdata_i  = $urandom;
    end
  endtask

  // Compare the address-phase outputs against the model, then advance the
  // model across the coming clock edge.
  task automatic checkOutput();
    int              w;
    bit              exp_sreq;
    bit              hs;
    logic [NREQ-1:0] exp_gnt;
    logic [31:0]     rd;
    w = -1;
    if (held >= 0) begin
      w = held;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        int c;
        c = (last_win + i) % NREQ;
        if ((w < 0) && drv_req[c]) w = c;
      end
    end
    exp_sreq = (w >= 0) && (outst < MAX_OUTST);
    check_value("s_req", s_req_o, exp_sreq);
    if (exp_sreq)
      check_value("s_addr_phase", {s_we_o, s_be_o, s_addr_o, s_wdata_o},
                  {drv_we[w], drv_be[w], drv_addr[w], drv_wdata[w]});
    else
      check_value("s_idle_zero", {s_we_o, s_be_o, s_addr_o, s_wdata_o}, '0);
    exp_gnt = '0;
    if (exp_sreq && s_gnt_i) exp_gnt[w] = 1'b1;
    check_value("m_gnt", m_gnt_o, exp_gnt);
    check_value("busy", busy_o, (outst != 0) || (held >= 0));
    check_value("err", err_o, err_exp);

    hs = exp_sreq && s_gnt_i;
    if (s_rvalid_i && (outst == 0)) err_exp = 1'b1;
    if (s_rvalid_i && (outst > 0)) outst--;
    if (hs) begin
      rd = $urandom;
      exp_q.push_back('{w, rd});
      slave_q.push_back(rd);
      last_win = w;
      held     = -1;
      outst++;
      drv_req[w] = 1'b0;
      perf_exp[w]++;
    end else if (exp_sreq) begin
      held = w;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk_i);
    applyStimulus();
    #1;
    checkOutput();
  endtask

  task automatic run_phase(input int n, input int pn, input int pg, input int pr);
    p_new = pn;
    p_gnt = pg;
    p_rv  = pr;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Reset with busy inputs: every output must read 0 while rst_i is high.
  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1;
    p_new = 100;
    applyStimulus();
    s_gnt_i    = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check_value("reset_outputs",
                {m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_be_o,
                 s_addr_o, s_wdata_o, busy_o, err_o, perf_gnt_cnt_o}, '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    reset_model();
  endtask

  task automatic check_perf();
    logic [NREQ*32-1:0] pv;
    pv = '0;
`ifdef EROS_OBI_ARB_PERF_EN
    for (int k = 0; k < NREQ; k++) pv[k*32 +: 32] = perf_exp[k];
`endif
    check_value("perf_gnt_cnt", perf_gnt_cnt_o, pv);
  endtask

  // Response monitor: pops the expected issuer and data on every m_rvalid_o.
  rsp_t            mon_e;
  logic [NREQ-1:0] mon_v;
  always @(negedge clk_i) begin
    #2;
    if (m_rvalid_o != '0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rsp_unexpected: got m_rvalid_o=%b expected none", m_rvalid_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_v = '0;
        mon_v[mon_e.idx] = 1'b1;
        check_value("rsp_route", m_rvalid_o, mon_v);
        check_value("rsp_rdata", m_rdata_o, mon_e.rdata);
      end
    end
  end

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      drv_req[k]   = 1'b0;
      drv_we[k]    = 1'b0;
      drv_be[k]    = '0;
      drv_addr[k]  = '0;
      drv_wdata[k] = '0;
    end
    reset_model();
    doReset();

    // Fairness: everyone always requesting, port always granting.
    run_phase(20, 100, 100, 100);
    // Fill to MAX_OUTST with no responses, then let responses drain.
    run_phase(8, 100, 100, 0);
    run_phase(8, 0, 100, 100);
    // Lock: requests with the port stalled, then released.
    run_phase(4, 100, 0, 0);
    run_phase(4, 100, 100, 50);
    // Mixed random traffic.
    run_phase(400, 50, 60, 45);
    // Drain everything outstanding.
    run_phase(30, 0, 100, 100);
    check_value("drain_empty", exp_q.size(), 0);

    // Spurious response with nothing outstanding sets a sticky error.
    force_rv = 1'b1;
    run_phase(1, 0, 100, 0);
    check_value("spurious_no_rvalid", m_rvalid_o, '0);
    force_rv = 1'b0;
    run_phase(4, 0, 100, 0);

    // Refill, check counters, then reset with transactions in flight.
    doReset();
    run_phase(30, 50, 70, 40);
    run_phase(8, 100, 100, 0);
    check_perf();
    doReset();
    check_perf();

    // A stale response after reset must set the error flag.
    force_rv = 1'b1;
    run_phase(1, 0, 100, 0);
    force_rv = 1'b0;
    run_phase(6, 0, 100, 100);
    doReset();
    run_phase(3, 0, 100, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
